instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch front end; the initiator side of the combinational word-indexed instruction memory (256 x 32 ROM).
- Holds the program counter and drives the memory word address each cycle.
- Captures the returned instruction together with its PC into a 2-entry queue.
- Presents entries to decode over a valid/ready handshake; supports redirect (branch/jump) with flush and a fetch-enable stall.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- IMEM_WORDS, 256, number of valid instruction words; word index >= IMEM_WORDS is a fetch fault.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_en  input  1  1 = fetching allowed; 0 = hold PC and issue no pushes.
- redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  input  32  redirect byte address.
- imem_addr  output  32  word index to instruction memory, equal to {2'b00, pc[31:2]}; combinational from pc.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- out_valid  output  1  queue head holds a valid entry.
- out_ready  input  1  decode accepts head this cycle.
- out_pc  output  32  byte PC of head entry.
- out_instr  output  32  instruction of head entry.
- out_fault  output  1  head entry was fetched out of range.
- pc_o  output  32  current fetch PC (debug).

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC with low 2 bits forced to 0; queue empty.
  - out_valid=0, out_pc=0, out_instr=32'h0000_0013 (NOP), out_fault=0.
  - Reset mid-operation discards all entries and any pending redirect.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count<2 | pop).
  - On push: the entry {pc, imem_instr or NOP, fault} is written to the queue tail, and pc <= pc+4.
  - 32-bit wrap: 0xFFFF_FFFC -> 0x0000_0000.
- fault = (pc[31:2] >= IMEM_WORDS).
  - The faulting entry carries instr=32'h0000_0013 and fault=1.
  - Fetch continues; decode/trap logic owns the response.
- Output is the registered queue head; an entry pushed at edge N is visible at out_* after edge N.
  - Latency from reset release to first out_valid=1 is 1 cycle (out_pc=RESET_PC).
- Queue full (count=2) without pop: no push, pc holds, and imem_addr stays stable.
- Queue full with pop in the same cycle: push and pop occur together and count stays 2.
- Empty queue with push: count goes 0->1; pop is impossible since out_valid=0.
- Head entry remains stable while out_valid=1 and out_ready=0 (standard valid/ready hold rule).
- redirect_valid=1 has priority over everything:
  - The queue is flushed (count=0), and any pop or push that cycle is discarded.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - out_valid=0 the next cycle.
  - First redirected entry is pushed on the following edge, giving out_valid=1 two edges after the redirect edge.
- Redirect with fetch_en=0: the flush and pc load still happen; no pushes occur until fetch_en=1.
- Back-to-back redirects: the last one wins; each one flushes.
- fetch_en=0: pc holds, no push; pops still drain the queue.
- Queue counter is 2 bits wide with legal values 0..2; read/write pointers are 1 bit each.

Decomposition:
- Package instr_fetch_pkg:
  - NOP_INSTR=32'h0000_0013.
  - Default RESET_PC.
  - Fetch entry type {pc[31:0], instr[31:0], fault} (65 bits).
  - Queue depth constant 2.
- Sub-module fetch_queue: 2-entry synchronous FIFO with flush input.
  - Ports: clk, rst, flush, push, push_data, pop, head_valid, head_data, full.
  - Flush has priority over push and pop.

Test Plan:
- Reset release, fetch_en=1, out_ready=1, ROM words 0..3 = A,B,C,D:
  - Outputs (pc, instr) = (0,A), (4,B), (8,C), (C,D) on consecutive cycles.
  - imem_addr runs 0,1,2,3.
- out_ready=0 for 5 cycles after reset:
  - Queue fills with entries for pc 0 and 4, then pc_o holds at 8 and imem_addr holds at 2.
  - Head stays (0,A).
  - After out_ready=1, outputs 0,4,8 follow with no gap or duplicate.
- Redirect to 0x0000_0042 while the queue is full and out_ready=1:
  - Next cycle out_valid=0.
  - Following cycle out_pc=0x40 with instr = ROM[16].
  - Stale entries for pc 0/4 never appear.
- Simultaneous pop and redirect: the popped head counts as accepted once; no entry from before the redirect appears afterwards.
- Redirect to 0x0000_03FC, then continued fetch:
  - pc 0x3FC yields ROM[255] with fault=0.
  - pc 0x400 yields instr=0x0000_0013 with fault=1.
- Assert rst for one cycle mid-stream with the queue full:
  - Next cycle out_valid=0 and out_instr=0x0000_0013.
  - Fetch restarts at RESET_PC.
  - With fetch_en=0 held, pc_o stays constant and out_valid=0 after the drain.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instr_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          QUEUE_DEPTH      = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  localparam fetch_entry_t IDLE_ENTRY = '{pc: 32'h0, instr: NOP_INSTR, fault: 1'b0};

  function automatic logic [31:0] word_index(input logic [31:0] byte_pc);
    return {2'b00, byte_pc[31:2]};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched {pc, instr, fault} entries; flush beats push and pop.
module fetch_queue import instr_fetch_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic         head_valid,
  output fetch_entry_t head_data,
  output logic         full
);

  fetch_entry_t mem [QUEUE_DEPTH];
  logic [1:0]   count;
  logic         wptr;
  logic         rptr;
  logic         do_push;
  logic         do_pop;

  assign full       = (count == 2'(QUEUE_DEPTH));
  assign head_valid = (count != 2'd0);
  assign do_pop     = pop & head_valid;
  assign do_push    = push & (~full | do_pop);

  // Empty queue presents the idle entry so decode sees a NOP with pc 0.
  assign head_data  = head_valid ? mem[rptr] : IDLE_ENTRY;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= 2'd0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (do_push) wptr <= ~wptr;
      if (do_pop)  rptr <= ~rptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: PC register driving the instruction ROM, feeding a 2-entry queue to decode.
module instr_fetch import instr_fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault,
  output logic [31:0] pc_o
);

  logic [31:0]  pc_p0;
  logic         fault_p0;
  logic         vld_p0;
  fetch_entry_t entry_p0;
  fetch_entry_t head_p1;
  logic         vld_p1;
  logic         pop;
  logic         full;
  logic         unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Stage p0: PC addresses the ROM, the returned word is checked and packed.
  assign imem_addr = word_index(pc_p0);
  assign fault_p0  = (imem_addr >= IMEM_WORDS);
  assign entry_p0  = '{pc: pc_p0, instr: (fault_p0 ? NOP_INSTR : imem_instr), fault: fault_p0};

  assign pop    = vld_p1 & out_ready;
  assign vld_p0 = fetch_en & ~redirect_valid & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0 <= {RESET_PC[31:2], 2'b00};
    end else if (redirect_valid) begin
      pc_p0 <= {redirect_pc[31:2], 2'b00};
    end else if (vld_p0) begin
      pc_p0 <= pc_p0 + 32'd4;
    end
  end

  // Stage p1: queued entries presented to decode.
  fetch_queue u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (vld_p0),
    .push_data  (entry_p0),
    .pop        (pop),
    .head_valid (vld_p1),
    .head_data  (head_p1),
    .full       (full)
  );

  assign out_valid = vld_p1;
  assign out_pc    = head_p1.pc;
  assign out_instr = head_p1.instr;
  assign out_fault = head_p1.fault;
  assign pc_o      = pc_p0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard of accepted decode entries.
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;
  logic [31:0] pc_o;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb [$];
  exp_t e;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault),
    .pc_o           (pc_o)
  );

  function automatic logic [31:0] rom_word(input logic [7:0] i);
    return 32'h1357_0000 | {16'h0, ~i, i};
  endfunction

  // Out-of-range reads return a marker that must never reach decode.
  assign imem_instr = (imem_addr < 32'd256) ? rom_word(imem_addr[7:0]) : 32'hDEAD_BEEF;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    sb.push_back('{pc: pc, instr: instr, fault: fault});
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_entry: got pc=%h instr=%h fault=%b expected none", out_pc, out_instr, out_fault);
      end else begin
        e = sb.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr || out_fault !== e.fault) begin
          miscompares++;
          $display("FAIL entry: got pc=%h instr=%h fault=%b expected pc=%h instr=%h fault=%b",
                   out_pc, out_instr, out_fault, e.pc, e.instr, e.fault);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    step(2);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, NOP);
    chk("rst_fault", {31'h0, out_fault}, 32'h0);
    chk("rst_pc_o", pc_o, 32'h0);

    // Streaming fetch with decode always ready.
    rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    expect_entry(32'h0, rom_word(8'd0), 1'b0);
    expect_entry(32'h4, rom_word(8'd1), 1'b0);
    expect_entry(32'h8, rom_word(8'd2), 1'b0);
    expect_entry(32'hC, rom_word(8'd3), 1'b0);
    chk("addr0", imem_addr, 32'd0);
    step();
    chk("addr1", imem_addr, 32'd1);
    chk("first_valid", {31'h0, out_valid}, 32'h1);
    chk("first_pc", out_pc, 32'h0);
    step();
    chk("addr2", imem_addr, 32'd2);
    step();
    chk("addr3", imem_addr, 32'd3);
    step();
    fetch_en = 1'b0;
    step(3);
    chk("hold_pc_o", pc_o, 32'h10);
    chk("drained", {31'h0, out_valid}, 32'h0);

    // Backpressure fills the queue.
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0; fetch_en = 1'b1;
    step(5);
    chk("full_pc_o", pc_o, 32'h8);
    chk("full_addr", imem_addr, 32'd2);
    chk("full_head_pc", out_pc, 32'h0);
    chk("full_head_instr", out_instr, rom_word(8'd0));
    expect_entry(32'h0, rom_word(8'd0), 1'b0);
    expect_entry(32'h4, rom_word(8'd1), 1'b0);
    expect_entry(32'h8, rom_word(8'd2), 1'b0);
    expect_entry(32'hC, rom_word(8'd3), 1'b0);
    out_ready = 1'b1;
    step(3);

    // Redirect on a full queue while head 0xC is being accepted.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
    expect_entry(32'h40, rom_word(8'd16), 1'b0);
    step();
    redirect_valid = 1'b0;
    chk("redir_valid0", {31'h0, out_valid}, 32'h0);
    chk("redir_pc_o", pc_o, 32'h40);
    step();
    chk("redir_valid1", {31'h0, out_valid}, 32'h1);
    chk("redir_pc", out_pc, 32'h40);
    chk("redir_instr", out_instr, rom_word(8'd16));

    // Walk across the end of the ROM.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_03FC;
    step();
    redirect_valid = 1'b0;
    chk("edge_valid0", {31'h0, out_valid}, 32'h0);
    expect_entry(32'h3FC, rom_word(8'd255), 1'b0);
    expect_entry(32'h400, NOP, 1'b1);
    step();
    chk("last_pc", out_pc, 32'h3FC);
    chk("last_instr", out_instr, rom_word(8'd255));
    chk("last_fault", {31'h0, out_fault}, 32'h0);
    step();
    chk("oob_pc", out_pc, 32'h400);
    chk("oob_instr", out_instr, NOP);
    chk("oob_fault", {31'h0, out_fault}, 32'h1);
    fetch_en = 1'b0;
    step(2);
    chk("oob_drained", {31'h0, out_valid}, 32'h0);

    // Reset in the middle of a full queue.
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0; fetch_en = 1'b1;
    step(3);
    chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    rst = 1'b1; fetch_en = 1'b0;
    step();
    chk("midrst_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_instr", out_instr, NOP);
    chk("midrst_pc_o", pc_o, 32'h0);
    rst = 1'b0;
    step(3);
    chk("idle_pc_o", pc_o, 32'h0);
    chk("idle_valid", {31'h0, out_valid}, 32'h0);
    chk("idle_addr", imem_addr, 32'd0);
    fetch_en = 1'b1; out_ready = 1'b1;
    expect_entry(32'h0, rom_word(8'd0), 1'b0);
    step();
    chk("restart_pc", out_pc, 32'h0);
    fetch_en = 1'b0;
    step(3);

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
